// File: rtl/fe_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
//   PC_RESET_VALUE : core PC after reset; byte address of instruction word 0
//   RV32I_NOP      : ADDI x0,x0,0, handed to the core whenever a fetch faults
//   FETCH_FSM_t    : fetch sequencer states
//   FETCH_ERR_t    : fault cause reported alongside raw_bits
package fe_pkg;

  localparam logic [31:0] PC_RESET_VALUE = 32'h0400_0000;
  localparam logic [31:0] RV32I_NOP      = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } FETCH_FSM_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } FETCH_ERR_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Combinational address qualification for the fetch stage.
// Ports:
//   fetch_pc     in  32          byte PC from the core
//   misaligned   out 1           PC not on a 4-byte boundary
//   out_of_range out 1           PC below BASE_ADDR or past the last memory word
//   word_addr    out ADDR_WIDTH  word index into instruction memory
module fetch_addr_check
  import fe_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = PC_RESET_VALUE,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic [31:0]           fetch_pc,
  output logic                  misaligned,
  output logic                  out_of_range,
  output logic [ADDR_WIDTH-1:0] word_addr
);

  localparam logic [29:0] LAST_WORD_LIMIT = 30'(MEM_WORDS);

  // Word offset from the start of instruction memory. Wraps when the PC is
  // below BASE_ADDR, which is why that case is tested separately.
  logic [29:0] off_word;

  assign off_word     = 30'((fetch_pc - BASE_ADDR) >> 2);
  assign misaligned   = (fetch_pc[1:0] != 2'b00);
  assign out_of_range = (fetch_pc < BASE_ADDR) || (off_word >= LAST_WORD_LIMIT);
  assign word_addr    = off_word[ADDR_WIDTH-1:0];

endmodule

// File: rtl/rv32i_fetch_unit.sv
// Instruction-fetch stage feeding the RV32I core.
// Takes the core PC plus a level fetch request, runs a req/gnt/rvalid
// handshake to a variable-latency instruction memory and returns a
// registered instruction with a one-cycle valid pulse. Misaligned or
// out-of-range PCs and memory timeouts return a NOP with a fault cause.
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-low reset
//   fetch_req, fetch_pc    request from the core, held until fetch_valid
//   flush                  abandon any in-flight fetch
//   mem_req, mem_addr      request / word address towards memory
//   mem_gnt                memory accepted the request
//   mem_rvalid, mem_rdata  read response
//   raw_bits               fetched instruction, held between fetches
//   fetch_valid, fetch_err one-cycle completion pulse and fault flag
//   err_cause              fault cause, held with raw_bits
module rv32i_fetch_unit
  import fe_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = PC_RESET_VALUE,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_WORDS),
  parameter int unsigned TIMEOUT    = 16,
  parameter logic [31:0] NOP_INSTR  = RV32I_NOP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_pc,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic [31:0]           raw_bits,
  output logic                  fetch_valid,
  output logic                  fetch_err,
  output logic [1:0]            err_cause
);

  localparam int unsigned      CNT_W     = $clog2(TIMEOUT + 1);
  // The grant cycle counts as the first of the TIMEOUT cycles, so WAIT
  // gives up once the incremented count reaches TIMEOUT-1.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] DROP_LAST = CNT_W'(TIMEOUT);

  FETCH_FSM_t            state_reg, state_next;
  FETCH_ERR_t            err_cause_reg;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;
  logic [31:0]           raw_bits_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  drop_pending_reg;

  logic                  misaligned;
  logic                  out_of_range;
  logic                  fault;
  logic                  wait_expired;
  logic [ADDR_WIDTH-1:0] word_addr;

  fetch_addr_check #(
    .BASE_ADDR  (BASE_ADDR),
    .MEM_WORDS  (MEM_WORDS),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_addr_check (
    .fetch_pc     (fetch_pc),
    .misaligned   (misaligned),
    .out_of_range (out_of_range),
    .word_addr    (word_addr)
  );

  assign fault        = misaligned | out_of_range;
  assign cnt_inc      = cnt_reg + CNT_W'(1);
  assign wait_expired = (cnt_inc == WAIT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fetch_req) state_next = fault ? DONE : REQ;
      REQ:     if (mem_gnt && !drop_pending_reg) state_next = WAIT;
      WAIT:    if (mem_rvalid || wait_expired) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Datapath: address, result, counter and stale-response tracking
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr_reg     <= '0;
      raw_bits_reg     <= NOP_INSTR;
      err_cause_reg    <= ERR_NONE;
      cnt_reg          <= '0;
      drop_pending_reg <= 1'b0;
    end else begin
      // A flushed WAIT still owes us one response; swallow it (or give up
      // after TIMEOUT cycles). The counter is free here because REQ is held
      // off while this flag is set, so no WAIT can overlap it.
      if (drop_pending_reg) begin
        cnt_reg <= cnt_inc;
        if (mem_rvalid || (cnt_inc == DROP_LAST)) drop_pending_reg <= 1'b0;
      end

      if (flush) begin
        // A response landing together with the flush is the one owed, so
        // only arm the drop when it has not arrived yet.
        if ((state_reg == WAIT) && !mem_rvalid) begin
          drop_pending_reg <= 1'b1;
          cnt_reg          <= '0;
        end
      end else begin
        case (state_reg)
          IDLE: begin
            if (fetch_req) begin
              if (fault) begin
                raw_bits_reg  <= NOP_INSTR;
                err_cause_reg <= misaligned ? ERR_MISALIGN : ERR_RANGE;
              end else begin
                mem_addr_reg <= word_addr;
              end
            end
          end
          REQ: begin
            if (mem_gnt && !drop_pending_reg) cnt_reg <= '0;
          end
          WAIT: begin
            cnt_reg <= cnt_inc;
            if (mem_rvalid) begin
              raw_bits_reg  <= mem_rdata;
              err_cause_reg <= ERR_NONE;
            end else if (wait_expired) begin
              raw_bits_reg  <= NOP_INSTR;
              err_cause_reg <= ERR_TIMEOUT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs decoded from state
  always_comb begin
    mem_req     = (state_reg == REQ) && !drop_pending_reg;
    fetch_valid = (state_reg == DONE);
    fetch_err   = (state_reg == DONE) && (err_cause_reg != ERR_NONE);
  end

  assign mem_addr  = mem_addr_reg;
  assign raw_bits  = raw_bits_reg;
  assign err_cause = err_cause_reg;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Testbench for rv32i_fetch_unit: a memory responder with per-fetch grant
// and response delays, a stimulus driver that pushes expected results from
// a behavioural model into a scoreboard queue, and a monitor that pops and
// compares whenever fetch_valid is seen.
`timescale 1ns/1ps
module tb_rv32i_fetch_unit;

  localparam logic [31:0] BASE  = 32'h0400_0000;
  localparam int          WORDS = 1024;
  localparam int          TOUT  = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        flush = 1'b0;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] raw_bits;
  logic        fetch_valid;
  logic        fetch_err;
  logic [1:0]  err_cause;

  rv32i_fetch_unit #(
    .BASE_ADDR  (BASE),
    .MEM_WORDS  (WORDS),
    .ADDR_WIDTH (10),
    .TIMEOUT    (TOUT),
    .NOP_INSTR  (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_pc    (fetch_pc),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .raw_bits    (raw_bits),
    .fetch_valid (fetch_valid),
    .fetch_err   (fetch_err),
    .err_cause   (err_cause)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] raw;
    logic [1:0]  cause;
    int          latency;     // cycles from request to fetch_valid; -1 = skip
    int          req_cycles;  // cycles mem_req is expected high
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem_model [WORDS];

  int          n_checks = 0;
  int          n_pass = 0;
  int          start_cyc = 0;
  int          cfg_gnt_delay = 0;
  int          cfg_rv_delay = 1;
  logic [9:0]  exp_addr = '0;
  int          req_hi = 0;
  bit          addr_bad = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model. g = cycles the grant is withheld, k = response delay
  // in cycles after the grant cycle (0 = never). The grant cycle is the
  // first of the TIMEOUT cycles, so k <= TOUT-1 returns data; otherwise
  // the fetch completes TOUT cycles after the grant with a NOP.
  function automatic exp_t model(input logic [31:0] pc, input int g, input int k);
    exp_t        e;
    logic [31:0] off;
    off = pc - BASE;
    if (pc % 4 != 0) begin
      e.raw = NOP; e.cause = 2'd1; e.latency = 1; e.req_cycles = 0;
    end else if (pc < BASE || off / 4 >= WORDS) begin
      e.raw = NOP; e.cause = 2'd2; e.latency = 1; e.req_cycles = 0;
    end else begin
      e.req_cycles = g + 1;
      if (k >= 1 && k <= TOUT - 1) begin
        e.raw = mem_model[off / 4]; e.cause = 2'd0; e.latency = g + 2 + k;
      end else begin
        e.raw = NOP; e.cause = 2'd3; e.latency = g + 1 + TOUT;
      end
    end
    return e;
  endfunction

  // Memory responder
  initial begin : responder
    int         req_wait;
    int         rv_cnt;
    int         rv_lat;
    bit         pend;
    logic [9:0] lat_addr;
    req_wait = 0; rv_cnt = 0; rv_lat = 0; pend = 1'b0; lat_addr = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      if (!rst) begin
        pend = 1'b0;
        req_wait = 0;
      end else begin
        if (pend) begin
          rv_cnt++;
          if (rv_cnt == rv_lat) begin
            mem_rvalid = 1'b1;
            mem_rdata = mem_model[lat_addr];
            pend = 1'b0;
          end
        end
        if (mem_req) begin
          req_hi++;
          if (mem_addr !== exp_addr) addr_bad = 1'b1;
          if (req_wait >= cfg_gnt_delay) begin
            mem_gnt = 1'b1;
            req_wait = 0;
            if (cfg_rv_delay > 0) begin
              pend = 1'b1; rv_cnt = 0; rv_lat = cfg_rv_delay; lat_addr = mem_addr;
            end
          end else begin
            req_wait++;
          end
        end
      end
    end
  end

  // Monitor: compares every fetch_valid against the scoreboard head
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && fetch_valid) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_valid: raw_bits %h with no fetch outstanding", raw_bits);
        end else begin
          e = sb_q.pop_front();
          $display("fetch done: raw_bits %h err_cause %0d fetch_err %0b latency %0d",
                   raw_bits, err_cause, fetch_err, cyc - start_cyc);
          check("raw_bits", raw_bits, e.raw);
          check("err_cause", 32'(err_cause), 32'(e.cause));
          check("fetch_err", 32'(fetch_err), 32'(e.cause != 2'd0));
          if (e.latency >= 0) check("latency", cyc - start_cyc, e.latency);
          check("mem_req_cycles", req_hi, e.req_cycles);
          check("mem_addr_stable", 32'(addr_bad), 32'd0);
        end
      end
    end
  end

  task automatic wait_valid();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fetch_valid && n < 100);
    if (!fetch_valid) begin
      n_checks++;
      $display("FAIL wait_valid: no fetch_valid within 100 cycles");
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc, input int g, input int k, input bit chk_lat = 1'b1);
    exp_t e;
    e = model(pc, g, k);
    if (!chk_lat) e.latency = -1;
    @(negedge clk);
    cfg_gnt_delay = g;
    cfg_rv_delay = k;
    exp_addr = 10'((pc - BASE) >> 2);
    req_hi = 0;
    addr_bad = 1'b0;
    start_cyc = cyc;
    sb_q.push_back(e);
    fetch_pc = pc;
    fetch_req = 1'b1;
    wait_valid();
    fetch_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_raw_bits"}, raw_bits, NOP);
    check({tag, "_fetch_valid"}, 32'(fetch_valid), 32'd0);
    check({tag, "_fetch_err"}, 32'(fetch_err), 32'd0);
    check({tag, "_err_cause"}, 32'(err_cause), 32'd0);
  endtask

  // Flush in WAIT, then a new fetch while the stale response is outstanding
  task automatic flush_test();
    mem_model[5] = 32'hDEAD_BEEF;
    mem_model[4] = 32'h0000_0033;
    @(negedge clk);
    cfg_gnt_delay = 0;
    cfg_rv_delay = 5;
    exp_addr = 10'd5;
    fetch_pc = BASE + 32'd20;
    fetch_req = 1'b1;
    repeat (3) @(negedge clk);   // second WAIT cycle
    fetch_req = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_keeps_raw", raw_bits, mem_model[3]);
    check("flush_keeps_cause", 32'(err_cause), 32'd0);
    do_fetch(BASE + 32'd16, 0, 1, 1'b0);
  endtask

  // Asynchronous reset in the middle of WAIT, then a normal fetch
  task automatic reset_test();
    @(negedge clk);
    cfg_gnt_delay = 0;
    cfg_rv_delay = 0;
    exp_addr = 10'd7;
    fetch_pc = BASE + 32'd28;
    fetch_req = 1'b1;
    repeat (4) @(negedge clk);
    #2.3 rst = 1'b0;
    #0.5 check_reset_outputs("midwait_reset");
    fetch_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_fetch(BASE + 32'd28, 1, 2);
  endtask

  task automatic random_fetches(input int count);
    int          sel;
    int          g;
    int          k;
    logic [31:0] pc;
    for (int i = 0; i < count; i++) begin
      sel = $urandom_range(0, 9);
      pc = BASE + 4 * $urandom_range(0, WORDS - 1);
      if (sel == 0) pc = pc + $urandom_range(1, 3);
      else if (sel == 1) pc = BASE + 32'h1000 + 4 * $urandom_range(0, 255);
      else if (sel == 2) pc = 4 * $urandom_range(0, 32'h00FF_FFFF);
      g = $urandom_range(0, 3);
      k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, TOUT - 1);
      do_fetch(pc, g, k);
    end
  endtask

  initial begin : main
    for (int i = 0; i < WORDS; i++) mem_model[i] = $urandom();
    mem_model[2] = 32'h0050_0093;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;

    do_fetch(BASE + 32'd8, 0, 1);           // ideal memory, valid in cycle 3
    do_fetch(BASE + 32'd6, 0, 1);           // misaligned
    do_fetch(BASE + 32'h1000, 0, 1);        // one past the last word
    do_fetch(BASE - 32'd4, 0, 1);           // below BASE
    do_fetch(BASE + 32'd4092, 0, 1);        // last word
    do_fetch(BASE + 32'd8, 5, 3);           // grant withheld 5 cycles
    do_fetch(BASE + 32'd12, 0, 0);          // no response: timeout
    do_fetch(BASE + 32'd12, 0, TOUT - 1);   // response on the last allowed cycle
    flush_test();
    reset_test();
    random_fetches(40);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rv32i_fetch_unit.md
Name: rv32i_fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the RV32I core and produces the raw instruction bits the core latches in its FETCH_S1 state.
- Takes the core's current program counter and a fetch request.
- Runs a req/gnt/rvalid handshake to a variable-latency instruction memory.
- Returns a registered 32-bit instruction with a valid pulse.
- Handles misalignment, out-of-range addresses, memory timeout and flush; each fault substitutes a NOP and flags an error.

Parameters:
BASE_ADDR, 32'h0400_0000, byte address of instruction memory word 0 (matches core PC reset value)
MEM_WORDS, 1024, instruction memory depth in 32-bit words
ADDR_WIDTH, 10, word-address width, equal to $clog2(MEM_WORDS)
TIMEOUT, 16, max cycles from grant to rvalid before fault
NOP_INSTR, 32'h0000_0013, substituted instruction on any fault (ADDI x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
fetch_req  in  1  core requests instruction at fetch_pc; level, held until fetch_valid
fetch_pc  in  32  byte PC from core (program_counter_s1); stable while fetch_req high
flush  in  1  abort any in-flight fetch; return to IDLE next cycle
mem_req  out  1  memory request
mem_addr  out  ADDR_WIDTH  word address
mem_gnt  in  1  memory accepted request this cycle
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
raw_bits  out  32  fetched instruction, held until next fetch_valid
fetch_valid  out  1  one-cycle pulse: raw_bits updated
fetch_err  out  1  one-cycle pulse coincident with fetch_valid on a fault
err_cause  out  2  0 none, 1 misaligned, 2 out-of-range, 3 timeout; held with raw_bits

Behaviour:
- Reset values (rst low, async): state IDLE, mem_req 0, mem_addr 0, raw_bits NOP_INSTR, fetch_valid 0, fetch_err 0, err_cause 0, timeout counter 0.
- Address calculation: off = fetch_pc - BASE_ADDR, computed in 32-bit unsigned arithmetic.
  - misaligned if fetch_pc[1:0] != 0;
  - out-of-range if fetch_pc < BASE_ADDR or off[31:2] >= MEM_WORDS;
  - otherwise mem_addr = off[ADDR_WIDTH+1:2].
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - fetch_req and a fault condition → DONE, loading raw_bits=NOP_INSTR and err_cause=1 or 2; no mem_req issued. Misaligned takes priority over out-of-range.
  - fetch_req and no fault → REQ; mem_addr is registered.
- REQ:
  - mem_req=1; mem_addr is held.
  - mem_gnt → WAIT, clear counter.
  - With no grant, stay in REQ indefinitely; no timeout applies before grant.
- WAIT:
  - mem_req=0; counter increments each cycle.
  - mem_rvalid → DONE, raw_bits=mem_rdata, err_cause=0.
  - Counter reaches TIMEOUT-1 without rvalid → DONE, raw_bits=NOP_INSTR, err_cause=3.
  - rvalid in the same cycle as the last count: data wins, no error.
- DONE:
  - fetch_valid=1 for exactly one cycle; fetch_err=1 if err_cause!=0.
  - Next state IDLE.
  - A new fetch_req is honoured no earlier than the cycle after DONE.
- Latency, ideal memory (gnt in REQ cycle, rvalid first WAIT cycle): request seen in IDLE at cycle 0 → fetch_valid in cycle 3. Fault path: fetch_valid in cycle 1.
- Flush has priority over every transition in any state.
  - Next state IDLE; no fetch_valid is produced; raw_bits and err_cause are unchanged.
  - An rvalid arriving in the same cycle as flush is dropped.
  - If flush is asserted in WAIT, the unit ignores one late rvalid: a drop_pending flag is set and cleared on the next rvalid or after TIMEOUT cycles.
  - A new request may proceed while drop_pending is set. Its REQ issue is gated until drop_pending clears.
- mem_rvalid outside WAIT with drop_pending clear is ignored (protocol error; no state change).
- Reset asserted mid-transaction: immediate return to reset values; drop_pending cleared.

Decomposition:
- Shared package fe_pkg:
  - typedef FETCH_FSM_t {IDLE, REQ, WAIT, DONE};
  - typedef FETCH_ERR_t (2-bit cause enum);
  - constant RV32I_NOP.
- BASE_ADDR default is taken from the existing RV32I defines for the PC reset value.
- One sub-module, fetch_addr_check: combinational misalign, range and word-address logic. It is unit-testable in isolation.
- FSM, counter and output registers stay in the top module.

Test Plan:
- Reset, then fetch_req with fetch_pc=0x0400_0008; mem gnt immediately, rvalid next cycle with rdata=0x00500093 → mem_addr=2, fetch_valid pulse in cycle 3, raw_bits=0x00500093, fetch_err=0.
- fetch_pc=0x0400_0006 → no mem_req, fetch_valid in cycle 1, raw_bits=0x00000013, err_cause=1. fetch_pc=0x0400_1000 (MEM_WORDS=1024) → err_cause=2.
- Grant withheld 5 cycles, then rvalid 3 cycles after grant → mem_req high 6 cycles with a stable address; valid data returned, no error.
- Grant given, rvalid never arrives → fetch_valid exactly TIMEOUT=16 cycles after grant, raw_bits=NOP, err_cause=3. Separately, rvalid exactly on the 16th cycle → data accepted, no error.
- Flush in WAIT, then new fetch at 0x0400_0010; stale rvalid (0xDEADBEEF) arrives, then the real one (0x00000033) → stale dropped, raw_bits=0x00000033, one fetch_valid only.
- Async rst low mid-WAIT (not clock aligned) → all outputs return to reset values immediately; a subsequent fetch completes normally.
